// File: rtl/approx_mult_pkg.sv
// Shared types and helpers for the approximate multiplier pipeline.
package approx_mult_pkg;

  typedef enum logic {
    MODE_EXACT  = 1'b0,
    MODE_APPROX = 1'b1
  } mode_e;

  localparam int MAX_W    = 16;
  localparam int MAX_COLS = 2 * MAX_W + 1;

  // Bit c is set when product column c survives truncation (c >= k, inside 2w).
  function automatic logic [MAX_COLS-1:0] col_mask(input int w, input int k);
    logic [MAX_COLS-1:0] m;
    m = '0;
    for (int c = 0; c < MAX_COLS; c++) begin
      if (c >= k && c < 2 * w) m[c] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/approx_mult_pipe_compress.sv
// Partial-product generation, column masking and carry-save reduction to a
// sum/carry pair.
module approx_pp_compress
  import approx_mult_pkg::*;
#(
  parameter int W = 8,
  parameter int K = 8
) (
  input  logic [W-1:0] x_i,
  input  logic [W-1:0] y_i,
  input  mode_e        mode_i,
  output logic [2*W:0] sum_o,
  output logic [2*W:0] carry_o
);

  localparam int SW = 2 * W + 1;
  localparam logic [SW-1:0] APPROX_MASK = SW'(col_mask(W, K));

  logic [SW-1:0] mask;
  logic [SW-1:0] row;
  logic [SW-1:0] s;
  logic [SW-1:0] c;
  logic [SW-1:0] ns;
  logic [SW-1:0] nc;

  // Each operand row is folded into the running sum/carry pair by a 3:2 stage.
  always_comb begin
    mask = (mode_i == MODE_APPROX) ? APPROX_MASK : {SW{1'b1}};
    row  = '0;
    s    = '0;
    c    = '0;
    ns   = '0;
    nc   = '0;
    for (int j = 0; j < W; j++) begin
      row = (SW'(x_i) << j) & {SW{y_i[j]}} & mask;
      ns  = s ^ c ^ row;
      nc  = ((s & c) | (s & row) | (c & row)) << 1;
      s   = ns;
      c   = nc;
    end
    sum_o   = s;
    carry_o = c;
  end

endmodule

// File: rtl/approx_mult_pipe.sv
// Two-stage exact/approximate unsigned multiplier with valid/ready handshakes:
// stage 1 holds the carry-save pair, stage 2 the resolved product.
module approx_mult_pipe
  import approx_mult_pkg::*;
#(
  parameter int           W    = 8,
  parameter int           K    = 8,
  parameter logic [2*W-1:0] COMP = '0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_x,
  input  logic [W-1:0]   in_y,
  input  logic           in_mode,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] out_z,
  output logic           out_mode
);

  logic           s1_valid_q, s1_valid_d;
  logic [2*W:0]   s1_sum_q,   s1_sum_d;
  logic [2*W:0]   s1_carry_q, s1_carry_d;
  mode_e          s1_mode_q,  s1_mode_d;
  logic           s2_valid_q, s2_valid_d;
  logic [2*W-1:0] s2_z_q,     s2_z_d;
  mode_e          s2_mode_q,  s2_mode_d;

  logic [2*W:0]   pp_sum;
  logic [2*W:0]   pp_carry;
  logic [2*W:0]   comp_sel;
  logic           adv2;

  approx_pp_compress #(.W(W), .K(K)) u_compress (
    .x_i     (in_x),
    .y_i     (in_y),
    .mode_i  (mode_e'(in_mode)),
    .sum_o   (pp_sum),
    .carry_o (pp_carry)
  );

  // Ready ripples back combinationally so a full pipe still accepts while draining.
  always_comb begin
    adv2     = !s2_valid_q || out_ready;
    in_ready = !s1_valid_q || adv2;
    comp_sel = (s1_mode_q == MODE_APPROX) ? {1'b0, COMP} : '0;

    s1_valid_d = s1_valid_q;
    s1_sum_d   = s1_sum_q;
    s1_carry_d = s1_carry_q;
    s1_mode_d  = s1_mode_q;
    s2_valid_d = s2_valid_q;
    s2_z_d     = s2_z_q;
    s2_mode_d  = s2_mode_q;

    if (in_ready) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_sum_d   = pp_sum;
        s1_carry_d = pp_carry;
        s1_mode_d  = mode_e'(in_mode);
      end
    end

    if (adv2) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_z_d    = (2*W)'(s1_sum_q + s1_carry_q + comp_sel);
        s2_mode_d = s1_mode_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_sum_q   <= '0;
      s1_carry_q <= '0;
      s1_mode_q  <= MODE_EXACT;
      s2_valid_q <= 1'b0;
      s2_z_q     <= '0;
      s2_mode_q  <= MODE_EXACT;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_sum_q   <= s1_sum_d;
      s1_carry_q <= s1_carry_d;
      s1_mode_q  <= s1_mode_d;
      s2_valid_q <= s2_valid_d;
      s2_z_q     <= s2_z_d;
      s2_mode_q  <= s2_mode_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_z     = s2_z_q;
  assign out_mode  = s2_mode_q;

endmodule

// File: tb/tb_approx_mult_pipe.sv
// Directed bench for approx_mult_pipe: W=8/K=8 with COMP=0 and COMP=128,
// plus a W=12/K=10 random stream against a bit-level column model.
module tb_approx_mult_pipe;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_x;
  logic [7:0]  in_y;
  logic        in_mode;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_z;
  logic        out_mode;

  logic        in_ready_c;
  logic        out_valid_c;
  logic [15:0] out_z_c;
  logic        out_mode_c;

  logic        in_valid12;
  logic        in_ready12;
  logic [11:0] x12;
  logic [11:0] y12;
  logic        m12;
  logic        out_valid12;
  logic [23:0] out_z12;
  logic        out_mode12;

  int          nAssert;
  int          nFail;
  int          delivered;
  int          idx;
  logic        acc;
  logic [63:0] qZ[$];
  logic        qM[$];
  logic [63:0] q12[$];
  logic [63:0] firstExp;
  logic [7:0]  sx[4];
  logic [7:0]  sy[4];
  logic [63:0] exp8[4];
  logic [63:0] expC[4];
  logic        expM[4];

  approx_mult_pipe #(.W(8), .K(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .in_mode(in_mode), .out_valid(out_valid),
    .out_ready(out_ready), .out_z(out_z), .out_mode(out_mode)
  );

  approx_mult_pipe #(.W(8), .K(8), .COMP(16'd128)) dutC (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_c),
    .in_x(in_x), .in_y(in_y), .in_mode(in_mode), .out_valid(out_valid_c),
    .out_ready(out_ready), .out_z(out_z_c), .out_mode(out_mode_c)
  );

  approx_mult_pipe #(.W(12), .K(10)) dut12 (
    .clk(clk), .rst(rst), .in_valid(in_valid12), .in_ready(in_ready12),
    .in_x(x12), .in_y(y12), .in_mode(m12), .out_valid(out_valid12),
    .out_ready(1'b1), .out_z(out_z12), .out_mode(out_mode12)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Column-by-column reference: every surviving bit product adds 2^(i+j).
  function automatic logic [63:0] refMult(input int w, input int k, input logic [63:0] comp,
                                          input logic [15:0] x, input logic [15:0] y,
                                          input logic mode);
    logic [63:0] acc64;
    acc64 = '0;
    for (int i = 0; i < w; i++)
      for (int j = 0; j < w; j++)
        if (x[i] && y[j] && (!mode || (i + j) >= k)) acc64 += (64'd1 << (i + j));
    if (mode) acc64 += comp;
    return acc64 & ((64'd1 << (2 * w)) - 64'd1);
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    nAssert++;
    assert (observed === expected)
    else begin
      nFail++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] x, input logic [7:0] y, input logic mode, input logic v);
    in_x     = x;
    in_y     = y;
    in_mode  = mode;
    in_valid = v;
    #1;
  endtask

  // One clock of the 8-bit pipe with scoreboard bookkeeping at the handshakes.
  task automatic stepCycle();
    if (out_valid && out_ready) begin
      if (qZ.size() == 0) checkOutput("spurious_out", out_valid, 0);
      else begin
        checkOutput("stream_z", out_z, qZ.pop_front());
        checkOutput("stream_mode", out_mode, qM.pop_front());
        delivered++;
      end
    end
    if (in_valid && in_ready) begin
      qZ.push_back(refMult(8, 8, 0, in_x, in_y, in_mode));
      qM.push_back(in_mode);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    nAssert    = 0;
    nFail      = 0;
    delivered  = 0;
    rst        = 1'b1;
    out_ready  = 1'b1;
    in_valid12 = 1'b0;
    x12        = '0;
    y12        = '0;
    m12        = 1'b0;
    applyStimulus(8'd0, 8'd0, 1'b0, 1'b0);

    @(posedge clk);
    #1;
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_out_z", out_z, 0);
    checkOutput("reset_out_mode", out_mode, 0);
    rst = 1'b0;
    #1;
    checkOutput("post_reset_in_ready", in_ready, 1);

    // Corner vectors: 255*255 both modes, 0x80*1 both modes; dutC adds 128 in approx mode.
    sx   = '{8'd255, 8'd255, 8'h80, 8'h80};
    sy   = '{8'd255, 8'd255, 8'h01, 8'h01};
    expM = '{1'b0, 1'b1, 1'b0, 1'b1};
    exp8 = '{64'd65025, 64'd63232, 64'd128, 64'd0};
    expC = '{64'd65025, 64'd63360, 64'd128, 64'd128};
    for (int k = 0; k < 6; k++) begin
      if (k < 4) applyStimulus(sx[k], sy[k], expM[k], 1'b1);
      else       applyStimulus(8'd0, 8'd0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      if (k == 0) checkOutput("latency_not_early", out_valid, 0);
      if (k >= 1 && k <= 4) begin
        checkOutput("corner_valid", out_valid, 1);
        checkOutput("corner_z", out_z, exp8[k-1]);
        checkOutput("corner_mode", out_mode, expM[k-1]);
        checkOutput("corner_comp_z", out_z_c, expC[k-1]);
      end
      if (k == 5) checkOutput("corner_drained", out_valid, 0);
    end

    // Sixteen back-to-back alternating-mode transactions at full rate.
    delivered = 0;
    for (int c = 0; c < 20; c++) begin
      if (c < 16) begin
        applyStimulus(8'($urandom), 8'($urandom), c[0], 1'b1);
        checkOutput("stream_in_ready", in_ready, 1);
      end else begin
        applyStimulus(8'd0, 8'd0, 1'b0, 1'b0);
      end
      stepCycle();
      checkOutput("stream_one_per_cycle", out_valid, (c >= 1 && c <= 16));
    end
    checkOutput("stream_delivered", delivered, 16);

    // Output stall: two accepts fill the pipe, then everything must hold.
    sx = '{8'h11, 8'h2f, 8'hc3, 8'hff};
    sy = '{8'h9a, 8'h47, 8'hee, 8'h81};
    firstExp  = refMult(8, 8, 0, {8'd0, sx[0]}, {8'd0, sy[0]}, 1'b0);
    out_ready = 1'b0;
    delivered = 0;
    idx       = 0;
    for (int c = 0; c < 5; c++) begin
      applyStimulus(sx[idx], sy[idx], idx[0], 1'b1);
      checkOutput("stall_in_ready", in_ready, (c < 2));
      acc = in_ready;
      stepCycle();
      if (acc) idx++;
      if (c >= 1) begin
        checkOutput("stall_out_valid", out_valid, 1);
        checkOutput("stall_out_z_stable", out_z, firstExp);
      end
    end
    out_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (idx < 4) applyStimulus(sx[idx], sy[idx], idx[0], 1'b1);
      else         applyStimulus(8'd0, 8'd0, 1'b0, 1'b0);
      acc = in_valid && in_ready;
      stepCycle();
      if (acc) idx++;
    end
    checkOutput("stall_delivered", delivered, 4);

    // Asynchronous reset with two transactions in flight.
    out_ready = 1'b0;
    applyStimulus(8'd200, 8'd201, 1'b1, 1'b1);
    stepCycle();
    applyStimulus(8'd50, 8'd60, 1'b0, 1'b1);
    stepCycle();
    applyStimulus(8'd0, 8'd0, 1'b0, 1'b0);
    checkOutput("inflight_valid", out_valid, 1);
    rst = 1'b1;
    #1;
    checkOutput("async_rst_out_valid", out_valid, 0);
    checkOutput("async_rst_out_z", out_z, 0);
    checkOutput("async_rst_out_mode", out_mode, 0);
    qZ.delete();
    qM.delete();
    @(posedge clk);
    #1;
    rst       = 1'b0;
    out_ready = 1'b1;
    delivered = 0;
    applyStimulus(8'd9, 8'd7, 1'b0, 1'b1);
    stepCycle();
    applyStimulus(8'd0, 8'd0, 1'b0, 1'b0);
    for (int c = 0; c < 6; c++) stepCycle();
    checkOutput("post_rst_delivered", delivered, 1);

    // W=12, K=10 random stream against the column model.
    for (int c = 0; c < 2004; c++) begin
      if (c < 2000) begin
        x12        = 12'($urandom);
        y12        = 12'($urandom);
        m12        = 1'($urandom);
        in_valid12 = 1'b1;
      end else begin
        in_valid12 = 1'b0;
      end
      #1;
      if (out_valid12) begin
        if (q12.size() == 0) checkOutput("rand_spurious", out_valid12, 0);
        else checkOutput("rand_z", out_z12, q12.pop_front());
      end
      if (in_valid12 && in_ready12) q12.push_back(refMult(12, 10, 0, {4'd0, x12}, {4'd0, y12}, m12));
      @(posedge clk);
      #1;
    end
    checkOutput("rand_drained", q12.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
